// File: rtl/gfp_pkg.sv
// gfp_pkg: shared types and GF(P) helpers for the systemizer.
//   state_e  - controller states
//   gfp_add / gfp_sub / gfp_mul - element arithmetic, operands already in 0..p-1
//   gfp_inv  - multiplicative inverse of x mod p (0 maps to 0, never used)
package gfp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PIVOT,
    NORM,
    ELIM,
    DONE,
    FAIL
  } state_e;

  function automatic int gfp_add(int p, int a, int b);
    return (a + b) % p;
  endfunction

  function automatic int gfp_sub(int p, int a, int b);
    return (a - b + p) % p;
  endfunction

  function automatic int gfp_mul(int p, int a, int b);
    return (a * b) % p;
  endfunction

  // Exhaustive search; only ever evaluated on constants to build a lookup table.
  function automatic int gfp_inv(int p, int x);
    int r;
    r = 0;
    for (int y = 1; y < p; y++) begin
      if ((x * y) % p == 1) r = y;
    end
    return r;
  endfunction

endpackage

// File: rtl/gfp_row_alu.sv
// gfp_row_alu: combinational K-lane row operation over GF(P).
//   a_i     - minuend row, K elements of W bits
//   b_i     - subtrahend row, same packing
//   s_i     - scalar multiplier for b_i
//   res_c_o - res[i] = (a[i] - s*b[i]) mod P
module gfp_row_alu
  import gfp_pkg::*;
#(
  parameter int unsigned K = 16,
  parameter int unsigned P = 3,
  parameter int unsigned W = $clog2(P)
) (
  input  logic [K*W-1:0] a_i,
  input  logic [K*W-1:0] b_i,
  input  logic [W-1:0]   s_i,
  output logic [K*W-1:0] res_c_o
);

  for (genvar i = 0; i < K; i++) begin : g_lane
    assign res_c_o[i*W +: W] = W'(gfp_sub(int'(P), int'(a_i[i*W +: W]),
                                          gfp_mul(int'(P), int'(s_i), int'(b_i[i*W +: W]))));
  end

endmodule

// File: rtl/gfp_systemizer.sv
// gfp_systemizer: Gauss-Jordan reduction over GF(P) of an L x K matrix held in
// registers, driving a left (columns 0..L-1) or right (K-L..K-1) window to identity.
//   clk, rst             - clock, synchronous active-high reset
//   start, side          - run request (IDLE only) and window select latched with it
//   busy, done           - non-IDLE status, one-cycle end-of-run pulse
//   success, fail        - sticky run outcome, cleared by an accepted start
//   rd_en/rd_addr/data_out - registered host read, 1-cycle latency, 0 while busy
//   wr_en/wr_addr/data_in  - host write, ignored while busy
//   cycles               - busy-cycle counter, present only with SYSTEMIZER_CYCLE_COUNT_EN
module gfp_systemizer
  import gfp_pkg::*;
#(
  parameter int unsigned L     = 8,
  parameter int unsigned K     = 16,
  parameter int unsigned P     = 3,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned W     = $clog2(P),
  parameter int unsigned AW    = $clog2(L * K / BLOCK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 side,
  output logic                 busy,
  output logic                 done,
  output logic                 success,
  output logic                 fail,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [BLOCK*W-1:0]   data_out,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [BLOCK*W-1:0]   data_in
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  ,
  output logic [15:0]          cycles
`endif
);

  localparam int unsigned RW     = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned CW     = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PW     = (K * W > 1) ? $clog2(K * W) : 1;
  localparam int unsigned WPR    = K / BLOCK;
  localparam int unsigned NWORDS = L * WPR;
  localparam int unsigned BW     = BLOCK * W;

  state_e          state_q, state_d;
  logic [RW-1:0]   c_q, c_d, r_q, r_d, e_q, e_d;
  logic            side_q, side_d;
  logic [K*W-1:0]  mem_q [L];

  logic            accept_c, swap_c, norm_c, elim_c;
  logic [CW-1:0]   wc;
  logic [W-1:0]    r_elem, c_elem, e_elem, inv_v, neg_inv;
  logic [K*W-1:0]  alu_a, alu_b, alu_res;
  logic [W-1:0]    alu_s;
  logic [W-1:0]    inv_tab [P];
  logic [BW-1:0]   word_view [NWORDS];
  logic [BW-1:0]   rd_word;

  // Constant inverse table.
  for (genvar v = 0; v < P; v++) begin : g_inv
    assign inv_tab[v] = W'(gfp_inv(int'(P), v));
  end

  // Flat word view of the array for host reads.
  for (genvar a = 0; a < NWORDS; a++) begin : g_word
    assign word_view[a] = mem_q[a / WPR][(a % WPR) * BW +: BW];
  end

  // Window column and the pivot-column elements of the rows in play.
  assign wc      = side_q ? CW'(K - L) + CW'(c_q) : CW'(c_q);
  assign r_elem  = mem_q[r_q][PW'(wc * W) +: W];
  assign c_elem  = mem_q[c_q][PW'(wc * W) +: W];
  assign e_elem  = mem_q[e_q][PW'(wc * W) +: W];
  assign inv_v   = inv_tab[c_elem];
  // -inv mod P, so that 0 - (-inv)*row = inv*row.
  assign neg_inv = (inv_v == '0) ? '0 : W'(P) - inv_v;

  always_comb begin
    rd_word = '0;
    if ({1'b0, rd_addr} < (AW + 1)'(NWORDS)) rd_word = word_view[rd_addr];
  end

  gfp_row_alu #(.K(K), .P(P), .W(W)) u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .s_i     (alu_s),
    .res_c_o (alu_res)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    r_d      = r_q;
    e_d      = e_q;
    side_d   = side_q;
    accept_c = 1'b0;
    swap_c   = 1'b0;
    norm_c   = 1'b0;
    elim_c   = 1'b0;
    alu_a    = mem_q[e_q];
    alu_b    = mem_q[c_q];
    alu_s    = e_elem;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          side_d   = side;
          c_d      = '0;
          r_d      = '0;
          state_d  = PIVOT;
        end
      end
      PIVOT: begin
        if (r_elem != '0) begin
          swap_c  = 1'b1;
          state_d = NORM;
        end else if (r_q == RW'(L - 1)) begin
          state_d = FAIL;
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      NORM: begin
        norm_c  = 1'b1;
        alu_a   = '0;
        alu_s   = neg_inv;
        e_d     = '0;
        state_d = ELIM;
      end
      ELIM: begin
        elim_c = (e_q != c_q);
        if (e_q == RW'(L - 1)) begin
          if (c_q == RW'(L - 1)) begin
            state_d = DONE;
          end else begin
            c_d     = c_q + RW'(1);
            r_d     = c_q + RW'(1);
            state_d = PIVOT;
          end
        end else begin
          e_d = e_q + RW'(1);
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, status outputs, host port and matrix array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      r_q      <= '0;
      e_q      <= '0;
      side_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      success  <= 1'b0;
      fail     <= 1'b0;
      data_out <= '0;
      for (int i = 0; i < L; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      r_q      <= r_d;
      e_q      <= e_d;
      side_q   <= side_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE) || (state_d == FAIL);
      if (accept_c) begin
        success <= 1'b0;
        fail    <= 1'b0;
      end
      if (state_d == DONE) success <= 1'b1;
      if (state_d == FAIL) fail    <= 1'b1;
      data_out <= (rd_en && (state_q == IDLE)) ? rd_word : '0;
      if (swap_c) begin
        mem_q[c_q] <= mem_q[r_q];
        mem_q[r_q] <= mem_q[c_q];
      end
      if (norm_c) mem_q[c_q] <= alu_res;
      if (elim_c) mem_q[e_q] <= alu_res;
      if (wr_en && (state_q == IDLE)) begin
        for (int a = 0; a < NWORDS; a++) begin
          if (wr_addr == AW'(a)) mem_q[RW'(a / WPR)][PW'((a % WPR) * BW) +: BW] <= data_in;
        end
      end
    end
  end

`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Busy-cycle counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (accept_c) begin
      cyc_q <= '0;
    end else if ((state_q != IDLE) && (cyc_q != 16'hFFFF)) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gfp_systemizer.sv
// tb_gfp_systemizer: self-checking bench for gfp_systemizer (L=8, K=16, P=3, BLOCK=4).
module tb_gfp_systemizer;

  localparam int L = 8, K = 16, P = 3, BLOCK = 4, W = 2, AW = 5;
  localparam int WPR = K / BLOCK, NW = L * WPR, BW = BLOCK * W;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, side = 1'b0;
  logic rd_en = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [BW-1:0] data_in = '0;
  logic busy, done, success, fail;
  logic [BW-1:0] data_out;
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
  logic [15:0] cycles;
`endif

  int checks = 0, errors = 0;
  int ini [L][K];
  int mdl [L][K];
  int got [L][K];
  logic [BW-1:0] gotw [NW];

  typedef struct {
    int pat;
    int sd;
    int exp_succ;
    int exp_fail;
    int exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  gfp_systemizer #(.L(L), .K(K), .P(P), .BLOCK(BLOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .side     (side),
    .busy     (busy),
    .done     (done),
    .success  (success),
    .fail     (fail),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .data_out (data_out),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .data_in  (data_in)
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic build(input int pat);
    int t;
    for (int r = 0; r < L; r++)
      for (int k = 0; k < K; k++) ini[r][k] = 0;
    case (pat)
      0: for (int r = 0; r < L; r++) begin
           ini[r][r] = 1;
           for (int k = L; k < K; k++) ini[r][k] = 1;
         end
      1: for (int r = 0; r < L; r++) begin
           ini[r][r] = 2;
           for (int k = L; k < K; k++) ini[r][k] = (r + k) % 3;
         end
      2: begin
           for (int r = 0; r < L; r++) begin
             ini[r][r] = 1;
             for (int k = L; k < K; k++) ini[r][k] = (r + 2 * k) % 3;
           end
           for (int k = 0; k < K; k++) begin
             t = ini[0][k]; ini[0][k] = ini[1][k]; ini[1][k] = t;
           end
         end
      3, 4: for (int r = 0; r < L; r++) begin
           ini[r][r] = (pat == 3 && r == 3) ? 0 : 1;
           for (int k = L; k < K; k++) ini[r][k] = (r + k) % 3;
         end
      5: for (int r = 0; r < L; r++) begin
           ini[r][K - L + r] = 1;
           for (int k = 0; k < K - L; k++) ini[r][k] = 2;
         end
      default: for (int r = 0; r < L; r++)
                 for (int k = 0; k < K; k++) ini[r][k] = $urandom_range(0, 2);
    endcase
    for (int r = 0; r < L; r++)
      for (int k = 0; k < K; k++) mdl[r][k] = ini[r][k];
  endtask

  // Reference Gauss-Jordan on mdl; latency is the scan/normalise/eliminate cycle count.
  task automatic ref_reduce(input int sd, output int ok, output int lat);
    int wc, pr, y, f, t;
    ok = 1;
    lat = 0;
    for (int c = 0; c < L; c++) begin
      wc = (sd != 0) ? K - L + c : c;
      pr = -1;
      for (int r = c; r < L; r++) if (pr < 0 && mdl[r][wc] != 0) pr = r;
      if (pr < 0) begin
        ok = 0;
        lat += L - c;
        return;
      end
      lat += (pr - c + 1) + 1 + L;
      for (int k = 0; k < K; k++) begin
        t = mdl[pr][k]; mdl[pr][k] = mdl[c][k]; mdl[c][k] = t;
      end
      y = 0;
      for (int v = 1; v < P; v++) if ((mdl[c][wc] * v) % P == 1) y = v;
      for (int k = 0; k < K; k++) mdl[c][k] = (mdl[c][k] * y) % P;
      for (int e = 0; e < L; e++) begin
        if (e != c) begin
          f = mdl[e][wc];
          for (int k = 0; k < K; k++) mdl[e][k] = ((mdl[e][k] - f * mdl[c][k]) % P + P) % P;
        end
      end
    end
  endtask

  task automatic load_ini();
    logic [BW-1:0] wd;
    for (int a = 0; a < NW; a++) begin
      wd = '0;
      for (int j = 0; j < BLOCK; j++) wd[j*W +: W] = W'(ini[a / WPR][(a % WPR) * BLOCK + j]);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); data_in = wd;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < NW; a++) begin
      @(negedge clk);
      rd_en = 1'b1; rd_addr = AW'(a);
      @(negedge clk);
      rd_en = 1'b0;
      gotw[a] = data_out;
      for (int j = 0; j < BLOCK; j++) got[a / WPR][(a % WPR) * BLOCK + j] = int'(data_out[j*W +: W]);
    end
  endtask

  function automatic logic [BW-1:0] mdl_word(input int a);
    logic [BW-1:0] wd;
    wd = '0;
    for (int j = 0; j < BLOCK; j++) wd[j*W +: W] = W'(mdl[a / WPR][(a % WPR) * BLOCK + j]);
    return wd;
  endfunction

  task automatic cmp_rows(input string tag);
    longint ga, ea;
    for (int r = 0; r < L; r++) begin
      ga = 0; ea = 0;
      for (int k = 0; k < K; k++) begin
        ga = ga * 4 + got[r][k];
        ea = ea * 4 + mdl[r][k];
      end
      check($sformatf("%s_row%0d", tag, r), ga, ea);
    end
  endtask

  // Start a run and wait for done; optionally inject a busy-time write/start/read at cycle inject_at.
  task automatic run(input int sd, input int inject_at, output int lat);
    @(negedge clk);
    start = 1'b1; side = sd[0];
    @(negedge clk);
    start = 1'b0; side = ~sd[0];
    lat = -1;
    for (int n = 0; n < 2000; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (inject_at >= 0 && n == inject_at) begin
        check("busy_during_run", busy, 1);
        wr_en = 1'b1; wr_addr = '0; data_in = 8'hAA;
        start = 1'b1; side = ~sd[0];
        rd_en = 1'b1; rd_addr = AW'(1);
      end
      if (inject_at >= 0 && n == inject_at + 1) begin
        wr_en = 1'b0; start = 1'b0; rd_en = 1'b0;
        check("read_while_busy", data_out, 0);
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("busy_at_done", busy, 1);
`ifdef SYSTEMIZER_CYCLE_COUNT_EN
      check("cycles_at_done", cycles, lat);
`endif
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    vec_t tbl [6];
    int lat, ok, mlat, sd, seen;

    tbl[0] = '{0, 0, 1, 0, 80};
    tbl[1] = '{1, 0, 1, 0, 80};
    tbl[2] = '{2, 0, 1, 0, 81};
    tbl[3] = '{3, 0, 0, 1, 35};
    tbl[4] = '{4, 0, 1, 0, 80};
    tbl[5] = '{5, 1, 1, 0, 80};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_success", success, 0);
    check("rst_fail", fail, 0);
    read_all();
    for (int a = 0; a < NW; a++) check($sformatf("rst_word%0d", a), gotw[a], 0);

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      build(tbl[t].pat);
      load_ini();
      ref_reduce(tbl[t].sd, ok, mlat);
      run(tbl[t].sd, -1, lat);
      check($sformatf("vec%0d_latency", t), lat, tbl[t].exp_lat);
      check($sformatf("vec%0d_success", t), success, tbl[t].exp_succ);
      check($sformatf("vec%0d_fail", t), fail, tbl[t].exp_fail);
      read_all();
      cmp_rows($sformatf("vec%0d", t));
      if (tbl[t].pat == 0) begin
        for (int r = 0; r < L; r++)
          for (int k = L; k < K; k++)
            if (got[r][k] != ini[r][k]) check($sformatf("vec0_right_unchanged_r%0dk%0d", r, k), got[r][k], ini[r][k]);
      end
      if (tbl[t].pat == 5) begin
        for (int r = 0; r < L; r++)
          check($sformatf("vec5_left_twos_r%0d", r), got[r][r] + got[r][0], 4);
      end
    end

    // Read and write of the same word in one cycle returns the old data.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; data_in = 8'h92;
    rd_en = 1'b1; rd_addr = '0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_same_cycle_old", data_out, mdl_word(0));
    @(negedge clk);
    rd_en = 1'b1; rd_addr = '0;
    @(negedge clk);
    rd_en = 1'b0;
    check("rw_then_new", data_out, 8'h92);

    // Write and start during busy are ignored.
    build(0);
    load_ini();
    ref_reduce(0, ok, mlat);
    run(0, 5, lat);
    check("busy_ignore_latency", lat, 80);
    check("busy_ignore_success", success, 1);
    read_all();
    cmp_rows("busy_ignore");

    // Randomised matrices against the reference model.
    for (int t = 0; t < 15; t++) begin
      sd = $urandom_range(0, 1);
      build(99);
      load_ini();
      ref_reduce(sd, ok, mlat);
      run(sd, -1, lat);
      check($sformatf("rnd%0d_latency", t), lat, mlat);
      check($sformatf("rnd%0d_success", t), success, ok);
      check($sformatf("rnd%0d_fail", t), fail, 1 - ok);
      read_all();
      cmp_rows($sformatf("rnd%0d", t));
    end

    // Reset mid-run aborts without a done pulse and clears the array.
    build(0);
    load_ini();
    @(negedge clk);
    start = 1'b1; side = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("midrun_busy_before_reset", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_success", success, 0);
    seen = 0;
    repeat (120) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrun_no_done", seen, 0);
    read_all();
    for (int a = 0; a < NW; a++) check($sformatf("midrun_word%0d", a), gotw[a], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfp_systemizer.md
Name: gfp_systemizer

Overview:
Next-generation systemizer. It runs Gauss-Jordan reduction over GF(P) on an L x K matrix held in an internal register array, so that a selected L x L window becomes the identity. Prime P is parametrised. Host load and unload use a BLOCK-element-wide addressed port. New over the previous generation: selectable left or right window, pivot row swapping, busy status, and a documented cycle budget. It sits directly under the chip-top wrapper.

Parameters:
- L, 8, matrix rows; also the window width. Constraint: L <= K.
- K, 16, matrix columns. Constraint: K % BLOCK == 0.
- P, 3, field modulus; prime, >= 2.
- BLOCK, 4, elements per host port word.
- W, CLOG2(P), derived; bits per element.
- AW, CLOG2(L*K/BLOCK), derived; host address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request reduction; accepted only in IDLE
- side  in  1  sampled at accepted start; 0 = window columns 0..L-1, 1 = window columns K-L..K-1
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse when a run ends
- success  out  1  sticky; window reduced to identity
- fail  out  1  sticky; singular window
- rd_en  in  1  host read strobe
- rd_addr  in  AW  host read word address
- data_out  out  BLOCK*W  read data; element j in bits [j*W +: W]
- wr_en  in  1  host write strobe
- wr_addr  in  AW  host write word address
- data_in  in  BLOCK*W  write data; same packing as data_out

Behaviour:
- Addressing: word a maps to row a/(K/BLOCK), columns (a%(K/BLOCK))*BLOCK .. +BLOCK-1.
- Reset: all outputs 0, array cleared to 0, state IDLE. Reset mid-run aborts the run immediately; no done pulse.
- Host read: registered, 1-cycle latency. Reads while busy or out of range return 0.
- Host write: takes effect the next cycle. Ignored while busy or out of range. A read and write to the same word in the same cycle returns the old data.
- start: accepted in IDLE only. On acceptance: success and fail clear, side is latched, c=0. Start while busy is ignored.
- State machine: IDLE -> PIVOT -> NORM -> ELIM -> (PIVOT | DONE | FAIL) -> IDLE. The window column is wc = c, or K-L+c when side=1.
- PIVOT: scans rows r = c..L-1, one row per cycle.
  - On the first M[r][wc] != 0: swap rows r and c in that cycle, go to NORM.
  - If r == L-1 and the element is zero: go to FAIL.
- NORM: row c = row c * inv(M[c][wc]) mod P. One cycle.
- ELIM: rows e = 0..L-1, one row per cycle. For e != c: row e -= M[e][wc] * row c (mod P), all K columns. e == c is a no-op cycle.
  - After e == L-1: c++. If c == L go to DONE, else go to PIVOT with r = c.
- DONE: success=1, done=1 for one cycle, return to IDLE.
- FAIL: fail=1, done=1 for one cycle, return to IDLE. The array is left partially reduced.
- Arithmetic: element-wise (a op b) mod P on W-bit values, never exceeding P-1. Inverse comes from a constant table indexed by value; inv(0) is unused.
- Latency per column: s + 1 + L cycles, s = pivot scan cycles (>= 1). The DONE state adds 1 cycle. For an identity window with L=8: 80 cycles from start acceptance to the done pulse.

Optional Feature:
- Macro: SYSTEMIZER_CYCLE_COUNT_EN.
- Defined: adds output cycles[15:0]. It clears on accepted start, increments every busy cycle, saturates at 16'hFFFF, holds after done, and resets to 0.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Decomposition:
- Package gfp_pkg holds:
  - state enum (IDLE, PIVOT, NORM, ELIM, DONE, FAIL);
  - mod-P add, sub and mul functions;
  - the inverse-table function gfp_inv(P, x).
- Natural sub-module gfp_row_alu: combinational K-wide row operation, out[i] = (a[i] - s*b[i]) mod P. NORM reuses it with a = 0 and s = -inv.

Test Plan (L=8, K=16, P=3, BLOCK=4):
- Reset, then read all 32 addresses -> data_out 0 each time. busy, done, success and fail are 0.
- Left window = I8, right half = 1s, start with side=0 -> done pulse exactly 80 cycles after acceptance, success=1, array unchanged on readback.
- Left window = 2*I8 -> success=1. Left window reads I8; right half elements are multiplied by 2 (mod 3).
- Rows 0 and 1 swapped in an I8 window -> row swap at c=0, success=1, window = I8.
- Column 3 of the window all zero -> fail=1, success=0, done pulse. A second start with a corrected matrix clears fail.
- Write at addr 0 and start pulse during busy -> both ignored. Reset asserted at cycle 20 of a run -> IDLE, busy=0, no done pulse, array reads 0.
- side=1 with the right window = I8 and the left half = 2s -> success=1, left half unchanged.
